// File: rtl/jt7759_pkg.sv
// rtl/jt7759_pkg.sv - shared JT7759 data-path defaults
package jt7759_pkg;

  localparam int JT7759_DW       = 8;
  localparam int JT7759_CNTW     = 5;
  localparam int JT7759_DRQ_WAIT = 31;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/jt7759_dfifo_mem.sv
// rtl/jt7759_dfifo_mem.sv - DEPTH x DW byte FIFO storage with occupancy tracking
module jt7759_dfifo_mem
  import jt7759_pkg::*;
#(
  parameter int DW = JT7759_DW,
  parameter int AW = 2
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = fifo_depth(AW);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Head is read combinationally so a same-cycle push into the popped slot is safe
  assign rdata = mem[rd_ptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (pop && !push) level <= level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/jt7759_dfifo.sv
// rtl/jt7759_dfifo.sv - buffered host data feeder with paced drqn; JT7759_DFIFO_OVF_EN enables the sticky ovf flag
module jt7759_dfifo
  import jt7759_pkg::*;
#(
  parameter int DW       = JT7759_DW,
  parameter int AW       = 2,
  parameter int CNTW     = JT7759_CNTW,
  parameter int DRQ_WAIT = JT7759_DRQ_WAIT
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          cen_ctl,
  input  logic          ctrl_flush,
  input  logic          ctrl_cs,
  output logic [DW-1:0] ctrl_din,
  output logic          ctrl_ok,
  input  logic          cs,
  input  logic          wrn,
  input  logic [DW-1:0] din,
  output logic          drqn,
  output logic [AW:0]   level,
  output logic          ovf
);

  localparam int DEPTH = fifo_depth(AW);

  logic            cen_ctl2;
  logic            wrl;
  logic            wr_edge;
  logic            pop;
  logic            push;
  logic            full;
  logic            empty;
  logic            req;
  logic [CNTW-1:0] cnt;
  logic [DW-1:0]   head;
  logic [AW+1:0]   demand;

  assign wr_edge = cs & ~wrn & ~wrl;
  assign pop     = ctrl_cs & ~ctrl_ok & ~empty & ~ctrl_flush;
  assign push    = wr_edge & (~full | pop) & ~ctrl_flush;
  // A request already in flight counts as a byte that will arrive
  assign demand  = {1'b0, level} + {{(AW+1){1'b0}}, ~drqn};
  assign req     = cen_ctl2 & ctrl_cs & (cnt == '0) & (demand < (AW+2)'(DEPTH));

  jt7759_dfifo_mem #(.DW(DW), .AW(AW)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctrl_flush),
    .push  (push),
    .pop   (pop),
    .wdata (din),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cen_ctl2 <= 1'b0;
      wrl      <= 1'b0;
      cnt      <= '0;
      drqn     <= 1'b1;
      ctrl_ok  <= 1'b0;
      ctrl_din <= '0;
    end else begin
      cen_ctl2 <= cen_ctl;
      wrl      <= cs & ~wrn;
      if (ctrl_flush) begin
        cnt     <= '0;
        drqn    <= 1'b1;
        ctrl_ok <= 1'b0;
      end else begin
        if (pop) begin
          ctrl_din <= head;
          ctrl_ok  <= 1'b1;
        end else if (!ctrl_cs) begin
          ctrl_ok  <= 1'b0;
        end
        if (wr_edge) begin
          drqn <= 1'b1;
          cnt  <= CNTW'(DRQ_WAIT);
        end else begin
          if (req) drqn <= 1'b0;
          if (cen_ctl2 && drqn && cnt != '0) cnt <= cnt - CNTW'(1);
        end
      end
    end
  end

`ifdef JT7759_DFIFO_OVF_EN
  always_ff @(posedge clk) begin
    if (rst || ctrl_flush)            ovf <= 1'b0;
    else if (wr_edge && full && !pop) ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
